// File: rtl/attest_guard.sv
// attest_guard: hardware monitor for a remote-attestation routine. It watches
// the CPU program counter, the data bus, interrupts and DMA channels. Any
// access pattern that could leak the key or corrupt the attestation routine
// forces a bounded-length MCU reset through the KILL state.
module attest_guard #(
  parameter int                 ADDR_W        = 16,
  parameter int                 DMA_CH        = 2,
  parameter logic [ADDR_W-1:0]  RESET_HANDLER = 16'h0000,
  parameter logic [ADDR_W-1:0]  CODE_BASE     = 16'hA000,
  parameter logic [ADDR_W-1:0]  CODE_END      = 16'hDFFE,
  parameter logic [ADDR_W-1:0]  KEY_BASE      = 16'h6A00,
  parameter logic [ADDR_W-1:0]  KEY_END       = 16'h6A3F,
  parameter logic [ADDR_W-1:0]  STACK_BASE    = 16'h0A00,
  parameter logic [ADDR_W-1:0]  STACK_END     = 16'h0DFF,
  parameter int                 RESET_CYCLES  = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [ADDR_W-1:0]        pc,
  input  logic                     data_en,
  input  logic                     data_wr,
  input  logic [ADDR_W-1:0]        data_addr,
  input  logic                     irq,
  input  logic [DMA_CH-1:0]        dma_en,
  input  logic [DMA_CH*ADDR_W-1:0] dma_addr,
  output logic                     hw_reset,
  output logic                     in_att,
  output logic [5:0]               viol_cause,
  output logic [7:0]               viol_count
);

  // Down-counter wide enough to hold RESET_CYCLES-1 (at least one bit).
  localparam int                CNT_W    = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(RESET_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    ATT  = 2'b01,
    KILL = 2'b10
  } state_t;

  state_t              state_r;
  logic [ADDR_W-1:0]   prev_pc_r;
  logic [CNT_W-1:0]    down_cnt_r;
  logic [5:0]          viol_cause_r;
  logic [7:0]          viol_count_r;
  logic                hw_reset_r;
  logic                in_att_r;

  logic                pc_in_code_s;
  logic [5:0]          viol_terms_s;
  logic                viol_any_s;
  logic                dma_hit_s;

  // Inclusive unsigned range test shared by every region compare.
  function automatic logic in_range(input logic [ADDR_W-1:0] addr,
                                    input logic [ADDR_W-1:0] lo,
                                    input logic [ADDR_W-1:0] hi);
    return (addr >= lo) && (addr <= hi);
  endfunction

  // A DMA address is sensitive when it falls in the key or the stack region.
  function automatic logic dma_sensitive(input logic [ADDR_W-1:0] addr);
    return in_range(addr, KEY_BASE, KEY_END) || in_range(addr, STACK_BASE, STACK_END);
  endfunction

  // Combinational violation terms, evaluated every cycle in every state.
  always_comb begin
    pc_in_code_s = in_range(pc, CODE_BASE, CODE_END);
    dma_hit_s    = 1'b0;
    for (int i = 0; i < DMA_CH; i++) begin
      if (dma_en[i] && (dma_sensitive(dma_addr[i*ADDR_W +: ADDR_W]) || (state_r == ATT))) begin
        dma_hit_s = 1'b1;
      end else begin
        dma_hit_s = dma_hit_s;
      end
    end
    viol_terms_s[0] = (state_r == IDLE) && pc_in_code_s && (pc != CODE_BASE);
    viol_terms_s[1] = (state_r == ATT) && !pc_in_code_s && (prev_pc_r != CODE_END);
    viol_terms_s[2] = (state_r == ATT) && irq;
    viol_terms_s[3] = data_en && in_range(data_addr, KEY_BASE, KEY_END) && !pc_in_code_s;
    viol_terms_s[4] = (state_r == ATT) && data_en && data_wr &&
                      !in_range(data_addr, STACK_BASE, STACK_END);
    viol_terms_s[5] = dma_hit_s;
    viol_any_s      = |viol_terms_s;
  end

  // Guard FSM with registered outputs, sticky cause flags and saturating count.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= IDLE;
      prev_pc_r    <= RESET_HANDLER;
      down_cnt_r   <= {CNT_W{1'b0}};
      viol_cause_r <= 6'b000000;
      viol_count_r <= 8'h00;
      hw_reset_r   <= 1'b0;
      in_att_r     <= 1'b0;
    end else begin
      prev_pc_r <= pc;
      case (state_r)
        IDLE, ATT: begin
          if (viol_any_s) begin
            state_r      <= KILL;
            hw_reset_r   <= 1'b1;
            in_att_r     <= 1'b0;
            down_cnt_r   <= CNT_LOAD;
            viol_cause_r <= viol_cause_r | viol_terms_s;
            if (viol_count_r != 8'hFF) begin
              viol_count_r <= viol_count_r + 8'h01;
            end else begin
              viol_count_r <= viol_count_r;
            end
          end else if ((state_r == IDLE) && (pc == CODE_BASE)) begin
            state_r    <= ATT;
            hw_reset_r <= 1'b0;
            in_att_r   <= 1'b1;
          end else if ((state_r == ATT) && !pc_in_code_s && (prev_pc_r == CODE_END)) begin
            state_r    <= IDLE;
            hw_reset_r <= 1'b0;
            in_att_r   <= 1'b0;
          end else begin
            state_r <= state_r;
          end
        end
        KILL: begin
          // Violations are ignored here; only the reset handler ends KILL.
          if ((down_cnt_r == {CNT_W{1'b0}}) && (pc == RESET_HANDLER)) begin
            state_r    <= IDLE;
            hw_reset_r <= 1'b0;
            in_att_r   <= 1'b0;
          end else if (down_cnt_r != {CNT_W{1'b0}}) begin
            down_cnt_r <= down_cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
          end else begin
            down_cnt_r <= down_cnt_r;
          end
        end
        default: begin
          // Unreachable encoding: fail safe into KILL.
          state_r    <= KILL;
          hw_reset_r <= 1'b1;
          in_att_r   <= 1'b0;
          down_cnt_r <= CNT_LOAD;
        end
      endcase
    end
  end

  assign hw_reset   = hw_reset_r;
  assign in_att     = in_att_r;
  assign viol_cause = viol_cause_r;
  assign viol_count = viol_count_r;

endmodule

// File: tb/tb_attest_guard.sv
// Directed testbench for attest_guard with hand-computed expectations.
module tb_attest_guard;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] pc;
  logic        data_en;
  logic        data_wr;
  logic [15:0] data_addr;
  logic        irq;
  logic [1:0]  dma_en;
  logic [31:0] dma_addr;
  logic        hw_reset;
  logic        in_att;
  logic [5:0]  viol_cause;
  logic [7:0]  viol_count;

  int n_cmp = 0;
  int n_mis = 0;

  attest_guard dut (
    .clk        (clk),
    .reset      (reset),
    .pc         (pc),
    .data_en    (data_en),
    .data_wr    (data_wr),
    .data_addr  (data_addr),
    .irq        (irq),
    .dma_en     (dma_en),
    .dma_addr   (dma_addr),
    .hw_reset   (hw_reset),
    .in_att     (in_att),
    .viol_cause (viol_cause),
    .viol_count (viol_count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet(input logic [15:0] p);
    pc = p; data_en = 1'b0; data_wr = 1'b0; data_addr = 16'h0000;
    irq = 1'b0; dma_en = 2'b00; dma_addr = 32'h0000_0000;
  endtask

  task automatic do_reset();
    quiet(16'h8000);
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  // Hold pc at the reset handler until hw_reset drops, bounded.
  task automatic recover(output int cycles);
    quiet(16'h0000);
    cycles = 0;
    while (hw_reset === 1'b1 && cycles < 20) begin
      step();
      cycles++;
    end
    n_cmp++;
    if (hw_reset !== 1'b0) begin
      n_mis++;
      $display("FAIL recover_timeout: hw_reset=%b after %0d cycles, want 0", hw_reset, cycles);
    end
  endtask

  task automatic test_reset();
    quiet(16'hA010);
    reset = 1'b1;  // violation-looking pc together with reset
    step();
    step();
    n_cmp++; if (hw_reset !== 1'b0) begin n_mis++; $display("FAIL reset_hw: got %b want 0", hw_reset); end
    n_cmp++; if (in_att !== 1'b0) begin n_mis++; $display("FAIL reset_att: got %b want 0", in_att); end
    n_cmp++; if (viol_cause !== 6'b000000) begin n_mis++; $display("FAIL reset_cause: got %b want 000000", viol_cause); end
    n_cmp++; if (viol_count !== 8'h00) begin n_mis++; $display("FAIL reset_count: got %h want 00", viol_count); end
    reset = 1'b0;
    quiet(16'h8000);
  endtask

  task automatic test_normal();
    logic [15:0] seq [6];
    logic        att_exp [6];
    seq = '{16'h8000, 16'h9FFE, 16'hA000, 16'hA002, 16'hDFFE, 16'h8000};
    att_exp = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      quiet(seq[i]);
      step();
      n_cmp++; if (in_att !== att_exp[i]) begin n_mis++; $display("FAIL normal_att[%0d]: got %b want %b", i, in_att, att_exp[i]); end
      n_cmp++; if (hw_reset !== 1'b0) begin n_mis++; $display("FAIL normal_hw[%0d]: got %b want 0", i, hw_reset); end
    end
    n_cmp++; if (viol_count !== 8'h00) begin n_mis++; $display("FAIL normal_count: got %h want 00", viol_count); end
  endtask

  task automatic test_entry_kill();
    int cyc;
    do_reset();
    quiet(16'hA010);
    step();
    n_cmp++; if (hw_reset !== 1'b1) begin n_mis++; $display("FAIL entry_hw: got %b want 1", hw_reset); end
    n_cmp++; if (viol_cause !== 6'b000001) begin n_mis++; $display("FAIL entry_cause: got %b want 000001", viol_cause); end
    n_cmp++; if (viol_count !== 8'h01) begin n_mis++; $display("FAIL entry_count: got %h want 01", viol_count); end
    recover(cyc);
    n_cmp++; if (cyc !== 4) begin n_mis++; $display("FAIL entry_kill_len: got %0d want 4", cyc); end
    n_cmp++; if (viol_cause !== 6'b000001) begin n_mis++; $display("FAIL entry_sticky: got %b want 000001", viol_cause); end
  endtask

  task automatic test_irq_stack();
    int cyc;
    do_reset();
    quiet(16'hA000);
    step();
    pc = 16'hA002; irq = 1'b1; data_en = 1'b1; data_wr = 1'b1; data_addr = 16'h2000;
    step();
    n_cmp++; if (hw_reset !== 1'b1) begin n_mis++; $display("FAIL irqstk_hw: got %b want 1", hw_reset); end
    n_cmp++; if (viol_cause !== 6'b010100) begin n_mis++; $display("FAIL irqstk_cause: got %b want 010100", viol_cause); end
    n_cmp++; if (viol_count !== 8'h01) begin n_mis++; $display("FAIL irqstk_count: got %h want 01", viol_count); end
    recover(cyc);
  endtask

  task automatic test_dma();
    int cyc;
    do_reset();
    quiet(16'h8000);
    dma_en = 2'b10; dma_addr = {16'h6A10, 16'h0000};
    step();
    n_cmp++; if (hw_reset !== 1'b1) begin n_mis++; $display("FAIL dma_hw: got %b want 1", hw_reset); end
    n_cmp++; if (viol_cause !== 6'b100000) begin n_mis++; $display("FAIL dma_cause: got %b want 100000", viol_cause); end
    // Violations while in KILL must not be recorded.
    quiet(16'hA010);
    data_en = 1'b1; data_addr = 16'h6A00; dma_en = 2'b01; dma_addr = {16'h0000, 16'h0A00};
    step();
    step();
    n_cmp++; if (viol_count !== 8'h01) begin n_mis++; $display("FAIL dma_kill_count: got %h want 01", viol_count); end
    n_cmp++; if (viol_cause !== 6'b100000) begin n_mis++; $display("FAIL dma_kill_cause: got %b want 100000", viol_cause); end
    recover(cyc);
  endtask

  task automatic test_boundaries();
    int cyc;
    do_reset();
    quiet(16'hDFFE);          // CODE_END is inside the region but not a legal entry
    step();
    n_cmp++; if (viol_cause !== 6'b000001) begin n_mis++; $display("FAIL bnd_entry_end: got %b want 000001", viol_cause); end
    recover(cyc);
    quiet(16'h8000); data_en = 1'b1; data_addr = 16'h6A40;  // just past key region
    step();
    n_cmp++; if (hw_reset !== 1'b0) begin n_mis++; $display("FAIL bnd_key_above: got %b want 0", hw_reset); end
    data_addr = 16'h6A3F;
    step();
    n_cmp++; if (viol_cause !== 6'b001001) begin n_mis++; $display("FAIL bnd_key_end: got %b want 001001", viol_cause); end
    n_cmp++; if (viol_count !== 8'h02) begin n_mis++; $display("FAIL bnd_key_count: got %h want 02", viol_count); end
    recover(cyc);
    quiet(16'hA000);
    step();
    pc = 16'hA004; data_en = 1'b1; data_addr = 16'h6A00;   // key read from code: legal
    step();
    data_wr = 1'b1; data_addr = 16'h0DFF;                   // top of stack: legal
    step();
    n_cmp++; if (in_att !== 1'b1 || hw_reset !== 1'b0) begin n_mis++; $display("FAIL bnd_legal_att: got att=%b hw=%b want 1/0", in_att, hw_reset); end
    quiet(16'h8000);          // leave from A004 instead of CODE_END
    step();
    n_cmp++; if (viol_cause !== 6'b001011) begin n_mis++; $display("FAIL bnd_exit: got %b want 001011", viol_cause); end
    n_cmp++; if (viol_count !== 8'h03) begin n_mis++; $display("FAIL bnd_exit_count: got %h want 03", viol_count); end
    recover(cyc);
    quiet(16'hA000);
    step();
    pc = 16'hA002; data_en = 1'b1; data_wr = 1'b1; data_addr = 16'h0E00;
    step();
    n_cmp++; if (viol_cause !== 6'b011011) begin n_mis++; $display("FAIL bnd_stack_above: got %b want 011011", viol_cause); end
    recover(cyc);
  endtask

  task automatic test_saturation();
    int cyc;
    do_reset();
    for (int i = 1; i <= 256; i++) begin
      quiet(16'hA010);
      step();
      recover(cyc);
      if (i == 255) begin
        n_cmp++; if (viol_count !== 8'hFF) begin n_mis++; $display("FAIL sat_255: got %h want ff", viol_count); end
      end
    end
    n_cmp++; if (viol_count !== 8'hFF) begin n_mis++; $display("FAIL sat_256: got %h want ff", viol_count); end
  endtask

  task automatic test_reset_mid_kill();
    do_reset();
    quiet(16'hA010);
    step();                   // first KILL cycle
    quiet(16'h0000);
    step();                   // second KILL cycle
    n_cmp++; if (hw_reset !== 1'b1) begin n_mis++; $display("FAIL midkill_pre: got %b want 1", hw_reset); end
    reset = 1'b1;
    step();
    reset = 1'b0;
    n_cmp++; if (hw_reset !== 1'b0) begin n_mis++; $display("FAIL midkill_hw: got %b want 0", hw_reset); end
    n_cmp++; if (viol_cause !== 6'b000000) begin n_mis++; $display("FAIL midkill_cause: got %b want 000000", viol_cause); end
    n_cmp++; if (viol_count !== 8'h00) begin n_mis++; $display("FAIL midkill_count: got %h want 00", viol_count); end
    quiet(16'hA000);          // only IDLE can enter ATT
    step();
    n_cmp++; if (in_att !== 1'b1) begin n_mis++; $display("FAIL midkill_idle: got in_att=%b want 1", in_att); end
  endtask

  initial begin
    reset = 1'b1;
    quiet(16'h8000);
    test_reset();
    test_normal();
    test_entry_kill();
    test_irq_stack();
    test_dma();
    test_boundaries();
    test_saturation();
    test_reset_mid_kill();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/attest_guard.md
ATTEST_GUARD -- requirements
Module: attest_guard

Interface
REQ-001 Parameter ADDR_W, 16, address and PC width in bits.
REQ-002 Parameter DMA_CH, 2, number of independent DMA channels monitored (1..8).
REQ-003 Parameter RESET_HANDLER, 16'h0000, PC value that ends the KILL state.
REQ-004 Parameter CODE_BASE / CODE_END, 16'hA000 / 16'hDFFE, inclusive attestation-code region; CODE_BASE is the only legal entry PC and CODE_END the only legal exit PC.
REQ-005 Parameter KEY_BASE / KEY_END, 16'h6A00 / 16'h6A3F, inclusive key region.
REQ-006 Parameter STACK_BASE / STACK_END, 16'h0A00 / 16'h0DFF, inclusive attestation stack region.
REQ-007 Parameter RESET_CYCLES, 4, minimum hw_reset assertion length in cycles (>=1).
REQ-008 clk  in  1  single clock; all state changes on its rising edge.
REQ-009 reset  in  1  synchronous, active-high reset.
REQ-010 pc  in  ADDR_W  current program counter.
REQ-011 data_en  in  1  CPU data-bus access strobe.
REQ-012 data_wr  in  1  CPU data-bus write qualifier (valid with data_en).
REQ-013 data_addr  in  ADDR_W  CPU data-bus address.
REQ-014 irq  in  1  interrupt taken.
REQ-015 dma_en  in  DMA_CH  per-channel DMA access strobe.
REQ-016 dma_addr  in  DMA_CH*ADDR_W  channel i address in bits [i*ADDR_W +: ADDR_W].
REQ-017 hw_reset  out  1  registered MCU reset request.
REQ-018 in_att  out  1  high while the FSM is in ATT.
REQ-019 viol_cause  out  6  sticky violation-cause flags.
REQ-020 viol_count  out  8  saturating count of violation events.

Function
REQ-021 The FSM SHALL have exactly three states, IDLE, ATT and KILL; all region compares SHALL be inclusive and unsigned.
REQ-022 Violation terms SHALL be evaluated combinationally each cycle: bit0 ENTRY = IDLE and pc in code region and pc != CODE_BASE; bit1 EXIT = ATT and pc outside code region and previous-cycle pc != CODE_END; bit2 IRQ = ATT and irq; bit3 KEY = data_en and data_addr in key region and pc outside code region; bit4 STACK = ATT and data_en and data_wr and data_addr outside stack region; bit5 DMA = any dma_en[i] with dma_addr[i] in key or stack region, or any dma_en[i] while in ATT.
REQ-023 IDLE->ATT SHALL occur when pc == CODE_BASE and no violation term is set; ATT->IDLE when pc outside code region, previous pc == CODE_END and no violation term is set.
REQ-024 From IDLE or ATT, any set violation term SHALL move the FSM to KILL on the next edge, with hw_reset high from that edge (latency 1 cycle).
REQ-025 On KILL entry the module SHALL OR all simultaneously set terms into viol_cause, load a down-counter with RESET_CYCLES-1, and increment viol_count by exactly 1, saturating at 8'hFF.
REQ-026 In KILL, violation terms SHALL be ignored (no cause update, no count).
REQ-027 KILL->IDLE SHALL occur only when the down-counter is zero and pc == RESET_HANDLER; hw_reset deasserts on that same edge, giving a minimum assertion of RESET_CYCLES cycles.
REQ-028 hw_reset SHALL be high exactly when the state is KILL; in_att SHALL be high exactly when the state is ATT.
REQ-029 The previous-pc register SHALL update every cycle, including in KILL.
REQ-030 viol_cause and viol_count SHALL be cleared only by reset, never by KILL exit.

Reset
REQ-031 With reset high at an edge: state = IDLE, hw_reset = 0, in_att = 0, viol_cause = 0, viol_count = 0, down-counter = 0, previous pc = RESET_HANDLER.
REQ-032 reset SHALL take priority over all transitions, including mid-KILL and a simultaneous violation.

Verification
REQ-033 pc 16'h8000 -> 16'hA000 -> 16'hA002 ... 16'hDFFE -> 16'h8000, no other activity -> in_att 1 from the cycle after A000 until the cycle after exit, hw_reset never 1, viol_count 0.
REQ-034 From IDLE, pc = 16'hA010 -> hw_reset 1 next cycle, viol_cause = 6'b000001, viol_count 1; pc = 16'h0000 held -> hw_reset low after exactly 4 cycles.
REQ-035 In ATT, irq = 1 and data write to 16'h2000 in the same cycle -> viol_cause = 6'b010100, viol_count 1.
REQ-036 DMA_CH = 2, dma_en = 2'b10, channel 1 address 16'h6A10, pc outside code -> KILL, viol_cause bit5; further violations during KILL leave viol_count at 1.
REQ-037 256 separate ENTRY violations with recovery between them -> viol_count stays 8'hFF after the 255th.
REQ-038 reset asserted on the second KILL cycle -> next cycle hw_reset 0, state IDLE, viol_cause 0, viol_count 0.
